// File: rtl/thdi_pkg.sv
// Shared widths and FSM encoding for the harmonic power DFT engine.
package thdi_pkg;

    localparam int unsigned FrameLen = 32;
    localparam int unsigned IdxW     = 5;
    localparam int unsigned TwFrac   = 14;
    localparam int unsigned SampleW  = 16;
    localparam int unsigned ProdW    = 32;
    localparam int unsigned AccW     = 38;
    localparam int unsigned RedW     = 22;
    localparam int unsigned SqW      = 44;
    localparam int unsigned PowW     = 48;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StPower
    } state_e;

endpackage

// File: rtl/dft_twiddle_rom.sv
// 32-entry Q1.14 cosine table; the upper half is the exact negation of the lower half
// so that every non-DC bin cancels a constant input exactly.
module dft_twiddle_rom
    import thdi_pkg::*;
(
    input  logic        [IdxW-1:0]    i_idx,
    output logic signed [SampleW-1:0] o_coef
);

    logic signed [SampleW-1:0] w_half;

    always_comb begin
        w_half = '0;
        unique case (i_idx[3:0])
            4'd0:  w_half = 16'sd16384;
            4'd1:  w_half = 16'sd16069;
            4'd2:  w_half = 16'sd15137;
            4'd3:  w_half = 16'sd13623;
            4'd4:  w_half = 16'sd11585;
            4'd5:  w_half = 16'sd9102;
            4'd6:  w_half = 16'sd6270;
            4'd7:  w_half = 16'sd3196;
            4'd8:  w_half = 16'sd0;
            4'd9:  w_half = -16'sd3196;
            4'd10: w_half = -16'sd6270;
            4'd11: w_half = -16'sd9102;
            4'd12: w_half = -16'sd11585;
            4'd13: w_half = -16'sd13623;
            4'd14: w_half = -16'sd15137;
            4'd15: w_half = -16'sd16069;
        endcase
    end

    assign o_coef = i_idx[4] ? -w_half : w_half;

endmodule

// File: rtl/thdi_dft_power.sv
// Frame DFT engine: one complex MAC per cycle over bins 1..HMax, reporting fundamental
// power and summed harmonic power once per frame.
module thdi_dft_power
    import thdi_pkg::*;
#(
    parameter int unsigned HMax = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [SampleW-1:0] d_in0,
    input  logic signed [SampleW-1:0] d_in1,
    input  logic signed [SampleW-1:0] d_in2,
    input  logic signed [SampleW-1:0] d_in3,
    input  logic signed [SampleW-1:0] d_in4,
    input  logic signed [SampleW-1:0] d_in5,
    input  logic signed [SampleW-1:0] d_in6,
    input  logic signed [SampleW-1:0] d_in7,
    input  logic signed [SampleW-1:0] d_in8,
    input  logic signed [SampleW-1:0] d_in9,
    input  logic signed [SampleW-1:0] d_in10,
    input  logic signed [SampleW-1:0] d_in11,
    input  logic signed [SampleW-1:0] d_in12,
    input  logic signed [SampleW-1:0] d_in13,
    input  logic signed [SampleW-1:0] d_in14,
    input  logic signed [SampleW-1:0] d_in15,
    input  logic signed [SampleW-1:0] d_in16,
    input  logic signed [SampleW-1:0] d_in17,
    input  logic signed [SampleW-1:0] d_in18,
    input  logic signed [SampleW-1:0] d_in19,
    input  logic signed [SampleW-1:0] d_in20,
    input  logic signed [SampleW-1:0] d_in21,
    input  logic signed [SampleW-1:0] d_in22,
    input  logic signed [SampleW-1:0] d_in23,
    input  logic signed [SampleW-1:0] d_in24,
    input  logic signed [SampleW-1:0] d_in25,
    input  logic signed [SampleW-1:0] d_in26,
    input  logic signed [SampleW-1:0] d_in27,
    input  logic signed [SampleW-1:0] d_in28,
    input  logic signed [SampleW-1:0] d_in29,
    input  logic signed [SampleW-1:0] d_in30,
    input  logic signed [SampleW-1:0] d_in31,
    output logic                      busy,
    output logic                      valid,
    output logic        [PowW-1:0]    p_fund,
    output logic        [PowW-1:0]    p_harm
);

    state_e                    r_state, w_state_d;
    logic                      r_start_q;
    logic signed [SampleW-1:0] r_x [FrameLen];
    logic        [IdxW-1:0]    r_k, r_n;
    logic signed [AccW-1:0]    r_re, r_im;
    logic        [PowW-1:0]    r_fund, r_harm;
    logic        [PowW-1:0]    r_p_fund, r_p_harm;
    logic                      r_valid;

    logic signed [SampleW-1:0] w_d_in [FrameLen];
    logic                      w_trig;
    logic                      w_load, w_mac, w_pow, w_last;
    logic        [IdxW-1:0]    w_cos_idx, w_sin_idx;
    logic signed [SampleW-1:0] w_x, w_cos, w_sin;
    logic signed [ProdW-1:0]   w_prod_re, w_prod_im;
    logic signed [RedW-1:0]    w_r, w_i;
    logic signed [SqW-1:0]     w_r_ext, w_i_ext, w_r_sq, w_i_sq;
    logic        [SqW-1:0]     w_p;
    logic        [PowW-1:0]    w_harm_sum;

    assign w_d_in[0]  = d_in0;
    assign w_d_in[1]  = d_in1;
    assign w_d_in[2]  = d_in2;
    assign w_d_in[3]  = d_in3;
    assign w_d_in[4]  = d_in4;
    assign w_d_in[5]  = d_in5;
    assign w_d_in[6]  = d_in6;
    assign w_d_in[7]  = d_in7;
    assign w_d_in[8]  = d_in8;
    assign w_d_in[9]  = d_in9;
    assign w_d_in[10] = d_in10;
    assign w_d_in[11] = d_in11;
    assign w_d_in[12] = d_in12;
    assign w_d_in[13] = d_in13;
    assign w_d_in[14] = d_in14;
    assign w_d_in[15] = d_in15;
    assign w_d_in[16] = d_in16;
    assign w_d_in[17] = d_in17;
    assign w_d_in[18] = d_in18;
    assign w_d_in[19] = d_in19;
    assign w_d_in[20] = d_in20;
    assign w_d_in[21] = d_in21;
    assign w_d_in[22] = d_in22;
    assign w_d_in[23] = d_in23;
    assign w_d_in[24] = d_in24;
    assign w_d_in[25] = d_in25;
    assign w_d_in[26] = d_in26;
    assign w_d_in[27] = d_in27;
    assign w_d_in[28] = d_in28;
    assign w_d_in[29] = d_in29;
    assign w_d_in[30] = d_in30;
    assign w_d_in[31] = d_in31;

    assign w_trig = start & ~r_start_q;

    // Sine is the cosine a quarter period back; its sign vanishes after squaring.
    assign w_cos_idx = r_k * r_n;
    assign w_sin_idx = w_cos_idx - IdxW'(8);

    dft_twiddle_rom u_rom_cos (
        .i_idx  (w_cos_idx),
        .o_coef (w_cos)
    );

    dft_twiddle_rom u_rom_sin (
        .i_idx  (w_sin_idx),
        .o_coef (w_sin)
    );

    assign w_x       = r_x[r_n];
    assign w_prod_re = ProdW'(w_x) * ProdW'(w_cos);
    assign w_prod_im = ProdW'(w_x) * ProdW'(w_sin);

    assign w_r        = RedW'(r_re >>> TwFrac);
    assign w_i        = RedW'(r_im >>> TwFrac);
    assign w_r_ext    = SqW'(w_r);
    assign w_i_ext    = SqW'(w_i);
    assign w_r_sq     = w_r_ext * w_r_ext;
    assign w_i_sq     = w_i_ext * w_i_ext;
    assign w_p        = $unsigned(w_r_sq) + $unsigned(w_i_sq);
    assign w_harm_sum = r_harm + PowW'(w_p);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_trig) w_state_d = StMac;
            StMac:   if (r_n == IdxW'(FrameLen - 1)) w_state_d = StPower;
            StPower: w_state_d = (r_k == IdxW'(HMax)) ? StIdle : StMac;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_mac  = 1'b0;
        w_pow  = 1'b0;
        unique case (r_state)
            StIdle:  w_load = w_trig;
            StMac:   w_mac  = 1'b1;
            StPower: w_pow  = 1'b1;
            default: ;
        endcase
        w_last = w_pow & (r_k == IdxW'(HMax));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
            r_valid   <= 1'b0;
            r_k       <= '0;
            r_n       <= '0;
            r_re      <= '0;
            r_im      <= '0;
            r_fund    <= '0;
            r_harm    <= '0;
            r_p_fund  <= '0;
            r_p_harm  <= '0;
            for (int i = 0; i < FrameLen; i++) r_x[i] <= '0;
        end else begin
            r_start_q <= start;
            r_valid   <= w_last;
            if (w_load) begin
                for (int i = 0; i < FrameLen; i++) r_x[i] <= w_d_in[i];
                r_k    <= IdxW'(1);
                r_n    <= '0;
                r_re   <= '0;
                r_im   <= '0;
                r_fund <= '0;
                r_harm <= '0;
            end
            if (w_mac) begin
                r_re <= r_re + AccW'(w_prod_re);
                r_im <= r_im + AccW'(w_prod_im);
                r_n  <= r_n + IdxW'(1);
            end
            if (w_pow) begin
                r_re <= '0;
                r_im <= '0;
                r_n  <= '0;
                if (r_k == IdxW'(1)) begin
                    r_fund <= PowW'(w_p);
                end else begin
                    r_harm <= w_harm_sum;
                end
                if (w_last) begin
                    r_p_fund <= r_fund;
                    r_p_harm <= w_harm_sum;
                end else begin
                    r_k <= r_k + IdxW'(1);
                end
            end
        end
    end

    assign busy   = (r_state != StIdle);
    assign valid  = r_valid;
    assign p_fund = r_p_fund;
    assign p_harm = r_p_harm;

endmodule

// File: tb/tb_thdi_dft_power.sv
// Directed bench for thdi_dft_power: impulses, DC, pure tones, held start and mid-frame reset.
module tb_thdi_dft_power;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [15:0] x [32];
    logic               busy, valid;
    logic [47:0]        p_fund, p_harm;

    int n_checks = 0;
    int n_pass   = 0;
    int ctab [16] = '{16384, 16069, 15137, 13623, 11585, 9102, 6270, 3196,
                      0, -3196, -6270, -9102, -11585, -13623, -15137, -16069};

    always #5 clk = ~clk;

    thdi_dft_power dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .d_in0  (x[0]),
        .d_in1  (x[1]),
        .d_in2  (x[2]),
        .d_in3  (x[3]),
        .d_in4  (x[4]),
        .d_in5  (x[5]),
        .d_in6  (x[6]),
        .d_in7  (x[7]),
        .d_in8  (x[8]),
        .d_in9  (x[9]),
        .d_in10 (x[10]),
        .d_in11 (x[11]),
        .d_in12 (x[12]),
        .d_in13 (x[13]),
        .d_in14 (x[14]),
        .d_in15 (x[15]),
        .d_in16 (x[16]),
        .d_in17 (x[17]),
        .d_in18 (x[18]),
        .d_in19 (x[19]),
        .d_in20 (x[20]),
        .d_in21 (x[21]),
        .d_in22 (x[22]),
        .d_in23 (x[23]),
        .d_in24 (x[24]),
        .d_in25 (x[25]),
        .d_in26 (x[26]),
        .d_in27 (x[27]),
        .d_in28 (x[28]),
        .d_in29 (x[29]),
        .d_in30 (x[30]),
        .d_in31 (x[31]),
        .busy   (busy),
        .valid  (valid),
        .p_fund (p_fund),
        .p_harm (p_harm)
    );

    function automatic int cosv(input int i);
        int j;
        j = i % 32;
        return (j >= 16) ? -ctab[j - 16] : ctab[j];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_range(input string tag, input logic [63:0] obs,
                             input logic [63:0] lo, input logic [63:0] hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) n_pass++;
        else $error("FAIL %s observed=%0d expected=[%0d..%0d]", tag, obs, lo, hi);
    endtask

    task automatic set_impulse(input logic signed [15:0] amp);
        for (int i = 0; i < 32; i++) x[i] = '0;
        x[0] = amp;
    endtask

    // One-cycle start pulse, then wait for valid; checks latency and handshake timing.
    task automatic run_frame(input string tag);
        int lat;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy_at_e0"}, 64'(busy), 64'd1);
        @(negedge clk) start = 1'b0;
        lat = 0;
        while (!valid && lat < 600) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd495);
        chk({tag, "_busy_in_valid"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_valid_falls"}, 64'(valid), 64'd0);
    endtask

    initial begin
        int nv;
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 32; i++) x[i] = '0;
        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_p_fund", 64'(p_fund), 64'd0);
        chk("rst_p_harm", 64'(p_harm), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        set_impulse(16'sd16384);
        run_frame("impulse");
        chk("impulse_p_fund", 64'(p_fund), 64'd268435456);
        chk("impulse_p_harm", 64'(p_harm), 64'd3758096384);

        set_impulse(-16'sd32768);
        run_frame("neg_impulse");
        chk("neg_impulse_p_fund", 64'(p_fund), 64'd1073741824);
        chk("neg_impulse_p_harm", 64'(p_harm), 64'd15032385536);

        for (int i = 0; i < 32; i++) x[i] = 16'sd1000;
        run_frame("dc");
        chk("dc_p_fund", 64'(p_fund), 64'd0);
        chk("dc_p_harm", 64'(p_harm), 64'd0);

        // R = 262144 +/- 64 gives R^2 in [68685926400, 68753035264]; small slack for I^2.
        for (int i = 0; i < 32; i++) x[i] = 16'(cosv(i));
        run_frame("cos1");
        chk_range("cos1_p_fund", 64'(p_fund), 64'd68685926400, 64'd68753039360);
        chk_range("cos1_p_harm", 64'(p_harm), 64'd0, 64'd4096);

        for (int i = 0; i < 32; i++) x[i] = 16'(cosv(3 * i));
        run_frame("cos3");
        chk_range("cos3_p_fund", 64'(p_fund), 64'd0, 64'd4096);
        chk_range("cos3_p_harm", 64'(p_harm), 64'd68685926400, 64'd68753043456);

        // Held start with a re-pulse mid-frame and samples scrambled after the trigger.
        set_impulse(16'sd16384);
        nv = 0;
        @(negedge clk) start = 1'b1;
        for (int cyc = 1; cyc <= 1100; cyc++) begin
            @(posedge clk); #1;
            if (valid) nv++;
            @(negedge clk);
            if (cyc == 2) for (int i = 0; i < 32; i++) x[i] = 16'($urandom_range(0, 65535));
            if (cyc == 200) start = 1'b0;
            if (cyc == 201) start = 1'b1;
            if (cyc == 1000) start = 1'b0;
        end
        chk("held_valid_count", 64'(nv), 64'd1);
        chk("held_p_fund", 64'(p_fund), 64'd268435456);
        chk("held_p_harm", 64'(p_harm), 64'd3758096384);

        // Asynchronous reset in the middle of a frame.
        set_impulse(16'sd16384);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk) start = 1'b0;
        repeat (199) @(posedge clk);
        #2;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(valid), 64'd0);
        chk("midrst_p_fund", 64'(p_fund), 64'd0);
        chk("midrst_p_harm", 64'(p_harm), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        run_frame("post_reset");
        chk("post_reset_p_fund", 64'(p_fund), 64'd268435456);
        chk("post_reset_p_harm", 64'(p_harm), 64'd3758096384);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
